psram_opi_resp: RTL

- Device-side OPI PSRAM responder, the far end of the PSRAM controller's octal bus.
- Decodes CE/SCK/IO[7:0] DDR transactions: a duplicated command byte, 4 address bytes, optional latency, then data.
- Serves mode-register accesses from an internal 8-entry register file and memory accesses through a simple synchronous memory port.
- Used as a synthesizable bus-functional device for controller verification and FPGA bring-up. SCK is generated from clk_i, so no synchronizers are used.

---
 rtl/psram_opi_resp.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/psram_opi_resp.sv
// Device-side OPI PSRAM responder: decodes DDR command/address/latency/data phases on the
// octal bus and serves an 8-entry mode-register file plus a synchronous memory port.
module psram_opi_resp #(
  parameter int unsigned MEM_AW  = 24,
  parameter logic [7:0]  MR0_RST = 8'h00,
  parameter logic [7:0]  MR4_RST = 8'h00
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              psram_sck_i,
  input  logic              psram_ce_i,
  input  logic [7:0]        psram_io_in_i,
  output logic [7:0]        psram_io_out_o,
  output logic [7:0]        psram_io_en_o,
  output logic              mem_rd_o,
  output logic              mem_wr_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic [7:0]        mem_wdata_o,
  input  logic [7:0]        mem_rdata_i,
  output logic              busy_o,
  output logic              err_o
);

  typedef enum logic [2:0] {StIdle, StCmd, StAddr, StWait, StData, StIgnore} state_e;

  localparam logic [7:0] CmdMrWr  = 8'hC0;
  localparam logic [7:0] CmdMrRd  = 8'h40;
  localparam logic [7:0] CmdMemWr = 8'h80;
  localparam logic [7:0] CmdMemRd = 8'h20;

  state_e            state_q, state_d;
  logic              sck_q, sck_prev_q, ce_q, ce_prev_q;
  logic [7:0]        io_q;
  logic [7:0]        cnt_q, cmd_q, out_q, wdata_q;
  logic [31:0]       addr_q, addr_nxt;
  logic [MEM_AW-1:0] ma_q;
  logic              rd_q, wr_q, rd_pend_q, err_q;
  logic [7:0]        mr_q [8];

  logic              sck_edge, cmd_ok, is_rd;
  logic [7:0]        rl, wl, wait_len, last_wait, pre_last;

  assign sck_edge  = !ce_q && (sck_q != sck_prev_q);
  assign addr_nxt  = (addr_q << 8) | {24'h0, io_q};
  assign cmd_ok    = (io_q == cmd_q) &&
                     (cmd_q == CmdMrWr || cmd_q == CmdMrRd ||
                      cmd_q == CmdMemWr || cmd_q == CmdMemRd);
  assign is_rd     = (cmd_q == CmdMrRd) || (cmd_q == CmdMemRd);
  assign rl        = 8'(mr_q[0][2:0]) + 8'd3;
  assign wl        = 8'(mr_q[4][7:5]) + 8'd3;
  // Command phase uses counts 0-1 and address 2-5, so wait starts at count 6.
  assign last_wait = 8'd5 + wait_len;
  assign pre_last  = 8'd4 + wait_len;

  always_comb begin
    wait_len = 8'd0;
    case (cmd_q)
      CmdMrRd, CmdMemRd: wait_len = {rl[6:0], 1'b0};
      CmdMemWr:          wait_len = {wl[6:0], 1'b0};
      default:           wait_len = 8'd0;
    endcase
  end

  // Input sampling and edge history.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sck_q      <= 1'b0;
      sck_prev_q <= 1'b0;
      ce_q       <= 1'b1;
      ce_prev_q  <= 1'b1;
      io_q       <= 8'h00;
    end else begin
      sck_q      <= psram_sck_i;
      sck_prev_q <= sck_q;
      ce_q       <= psram_ce_i;
      ce_prev_q  <= ce_q;
      io_q       <= psram_io_in_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= StIdle;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q != StIdle && ce_q) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: if (ce_prev_q && !ce_q) state_d = StCmd;
        StCmd:  if (sck_edge && cnt_q == 8'd1) state_d = cmd_ok ? StAddr : StIgnore;
        StAddr: if (sck_edge && cnt_q == 8'd5) state_d = (wait_len == 8'd0) ? StData : StWait;
        StWait: if (sck_edge && cnt_q == last_wait) state_d = StData;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q     <= 8'h00;
      cmd_q     <= 8'h00;
      addr_q    <= 32'h0;
      ma_q      <= '0;
      out_q     <= 8'h00;
      wdata_q   <= 8'h00;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      rd_pend_q <= 1'b0;
      err_q     <= 1'b0;
      for (int i = 0; i < 8; i++) mr_q[i] <= 8'h00;
      mr_q[0]   <= MR0_RST;
      mr_q[4]   <= MR4_RST;
    end else begin
      if (state_q == StIdle)                      cnt_q <= 8'h00;
      else if (sck_edge && cnt_q != 8'hFF)        cnt_q <= cnt_q + 8'd1;

      if (state_q == StCmd && sck_edge && cnt_q == 8'd0) cmd_q <= io_q;
      err_q <= (state_q == StCmd) && sck_edge && (cnt_q == 8'd1) && !cmd_ok;

      if (state_q == StAddr && sck_edge) addr_q <= addr_nxt;

      if (state_q == StAddr && sck_edge && cnt_q == 8'd5) ma_q <= addr_nxt[MEM_AW-1:0];
      else if (rd_q || wr_q)                              ma_q <= ma_q + MEM_AW'(1);

      // First read is prefetched so data is on the bus before the first data edge.
      rd_q <= (cmd_q == CmdMemRd) && sck_edge &&
              ((state_q == StWait && cnt_q == pre_last) || state_q == StData);
      wr_q <= (cmd_q == CmdMemWr) && sck_edge && (state_q == StData);
      if ((cmd_q == CmdMemWr) && sck_edge && (state_q == StData)) wdata_q <= io_q;

      rd_pend_q <= rd_q;
      if (rd_pend_q) begin
        out_q <= mem_rdata_i;
      end else if ((state_q == StWait || state_q == StData) && cmd_q == CmdMrRd) begin
        out_q <= mr_q[addr_q[2:0]];
      end

      if (state_q == StData && cmd_q == CmdMrWr && sck_edge && cnt_q == 8'd6)
        mr_q[addr_q[2:0]] <= io_q;
    end
  end

  always_comb begin
    busy_o         = (state_q != StIdle);
    psram_io_en_o  = (state_q == StData && !ce_q && is_rd) ? 8'hFF : 8'h00;
    psram_io_out_o = out_q;
    mem_rd_o       = rd_q;
    mem_wr_o       = wr_q;
    mem_addr_o     = ma_q;
    mem_wdata_o    = wdata_q;
    err_o          = err_q;
  end

endmodule
